alu_result_skid: RTL and testbench

//  Registered, back-pressurable output stage for the ALU/shifter datapath (ADD/SUB/AND/OR/SLL/SRA).

---
 rtl/alu_result_skid_pkg.sv | 13 +
 rtl/alu_result_entry.sv | 17 +
 rtl/alu_result_skid.sv | 80 ++++++++
 tb/tb_alu_result_skid.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/alu_result_skid_pkg.sv
// alu_result_skid_pkg: shared defaults, FSM state encoding and entry layout helper
//   DEF_DATA_W/DEF_REG_W/DEF_CNT_W : default widths for result, rd index and stall counter
//   state_t                        : EMPTY=00, ONE=01, FULL=10
//   entry_w()                      : width of the packed entry {result,rd,wren,ovf,neq,lt}
package alu_result_skid_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_W = 5;
  localparam int DEF_CNT_W = 16;
  typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b01, FULL = 2'b10} state_t;
  function automatic int entry_w(input int dw, input int rw);
    return dw + rw + 4;
  endfunction
endpackage

// File: rtl/alu_result_entry.sv
// alu_result_entry: resettable packed-entry register with load enable
//   clock, resetn : clock and asynchronous active-low reset (clears q)
//   load          : capture d on the rising edge
//   d / q         : packed entry in / held entry out
module alu_result_entry #(
  parameter int W = 41
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) q <= '0;
    else if (load) q <= d;
endmodule

// File: rtl/alu_result_skid.sv
// alu_result_skid: registered valid/ready output stage with 2-entry skid buffer for ALU results
//   clock, resetn           : clock, asynchronous active-low reset
//   in_valid/in_ready       : upstream handshake; in_ready is a register
//   in_result..in_lt        : ALU result, rd, wren and flags
//   flush                   : drops all held entries on the next edge
//   out_valid/out_ready     : writeback handshake; MAIN entry is always the head
//   out_result..out_lt      : head entry fields
//   stall_cnt               : saturating count of out_valid & !out_ready cycles
module alu_result_skid
  import alu_result_skid_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W = DEF_REG_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [REG_W-1:0]  in_rd,
  input  logic              in_wren,
  input  logic              in_ovf,
  input  logic              in_neq,
  input  logic              in_lt,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [REG_W-1:0]  out_rd,
  output logic              out_wren,
  output logic              out_ovf,
  output logic              out_neq,
  output logic              out_lt,
  output logic [CNT_W-1:0]  stall_cnt
);
  localparam int EW = entry_w(DATA_W, REG_W);
  state_t state, state_nxt;
  logic in_fire, out_fire, main_ld, skid_ld, wren_eff;
  logic [REG_W-1:0] rd_eff;
  logic [EW-1:0] in_entry, main_d, main_q, skid_q;
  assign in_fire = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  // Overflowing results never write the register file; rd is zeroed whenever wren is.
  assign wren_eff = in_wren & ~in_ovf;
  assign rd_eff = wren_eff ? in_rd : {REG_W{1'b0}};
  assign in_entry = {in_result, rd_eff, wren_eff, in_ovf, in_neq, in_lt};
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      state <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      state <= state_nxt;
      in_ready <= state_nxt != FULL;
    end
  always_comb begin
    state_nxt = state;
    if (flush) state_nxt = EMPTY;
    else
      case (state)
        EMPTY: state_nxt = in_fire ? ONE : EMPTY;
        ONE: state_nxt = (in_fire && !out_fire) ? FULL : (!in_fire && out_fire) ? EMPTY : ONE;
        FULL: state_nxt = out_fire ? ONE : FULL;
        default: state_nxt = EMPTY;
      endcase
  end
  // Loads are suppressed on flush so the head fields keep their last value.
  always_comb begin
    main_ld = !flush && ((in_fire && (state == EMPTY || (state == ONE && out_fire))) || (state == FULL && out_fire));
    skid_ld = !flush && state == ONE && in_fire && !out_fire;
    main_d = state == FULL ? skid_q : in_entry;
  end
  alu_result_entry #(.W(EW)) u_main (.clock(clock), .resetn(resetn), .load(main_ld), .d(main_d), .q(main_q));
  alu_result_entry #(.W(EW)) u_skid (.clock(clock), .resetn(resetn), .load(skid_ld), .d(in_entry), .q(skid_q));
  assign out_valid = state != EMPTY;
  assign {out_result, out_rd, out_wren, out_ovf, out_neq, out_lt} = main_q;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != {CNT_W{1'b1}}) stall_cnt <= stall_cnt + 1'b1;
endmodule

// File: tb/tb_alu_result_skid.sv
// tb_alu_result_skid: scoreboard bench for alu_result_skid (CNT_W=4 so saturation is reachable)
module tb_alu_result_skid;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 4;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic in_valid, in_ready, in_wren, in_ovf, in_neq, in_lt, flush;
  logic out_valid, out_ready, out_wren, out_ovf, out_neq, out_lt;
  logic [DW-1:0] in_result, out_result;
  logic [RW-1:0] in_rd, out_rd;
  logic [CW-1:0] stall_cnt, prev_cnt;
  logic [DW+RW+3:0] sb[$];
  logic [DW+RW+3:0] exp_e;
  logic w_eff;
  int checks = 0;
  int errors = 0;
  alu_result_skid #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW)) dut (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_rd(in_rd), .in_wren(in_wren), .in_ovf(in_ovf),
    .in_neq(in_neq), .in_lt(in_lt), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd), .out_wren(out_wren),
    .out_ovf(out_ovf), .out_neq(out_neq), .out_lt(out_lt), .stall_cnt(stall_cnt)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic drive(input logic [DW-1:0] r, input logic [RW-1:0] rd, input logic w, input logic o, input logic n, input logic l);
    in_valid = 1'b1;
    in_result = r;
    in_rd = rd;
    in_wren = w;
    in_ovf = o;
    in_neq = n;
    in_lt = l;
  endtask
  // Inputs change 1 time unit after posedge, so at negedge they show what the next edge sees.
  always @(negedge clock) begin
    if (!resetn) begin
      sb.delete();
      prev_cnt = '0;
    end else begin
      chk("no_x", 64'($isunknown({in_ready, out_valid, out_result, out_rd, out_wren, out_ovf, out_neq, out_lt, stall_cnt})), 64'd0);
      chk("stall_mono", 64'(stall_cnt >= prev_cnt), 64'd1);
      prev_cnt = stall_cnt;
      if (out_valid && out_ready) begin
        chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          exp_e = sb.pop_front();
          chk("fifo_order", 64'({out_result, out_rd, out_wren, out_ovf, out_neq, out_lt}), 64'(exp_e));
        end
      end
      if (flush) sb.delete();
      if (in_valid && in_ready && !flush) begin
        w_eff = in_wren & ~in_ovf;
        sb.push_back({in_result, w_eff ? in_rd : 5'd0, w_eff, in_ovf, in_neq, in_lt});
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    in_valid = 0; in_result = 0; in_rd = 0; in_wren = 0; in_ovf = 0; in_neq = 0; in_lt = 0;
    flush = 0; out_ready = 0;
    repeat (2) tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_result", 64'(out_result), 64'd0);
    chk("rst_stall", 64'(stall_cnt), 64'd0);
    resetn = 1'b1;
    tick();
    out_ready = 1'b1;
    drive(32'hFF000000, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_result", 64'(out_result), 64'hFF000000);
    chk("t1_rd", 64'(out_rd), 64'd5);
    tick();
    chk("t1_empty", 64'(out_valid), 64'd0);
    chk("t1_ready", 64'(in_ready), 64'd1);
    for (int i = 1; i <= 8; i++) begin
      drive(DW'(i), RW'(i), 1'b1, 1'b0, i[0], i[1]);
      tick();
      chk("t2_ready", 64'(in_ready), 64'd1);
      chk("t2_valid", 64'(out_valid), 64'd1);
      chk("t2_result", 64'(out_result), 64'(i));
    end
    in_valid = 1'b0;
    repeat (2) tick();
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive(DW'(i), 5'd7, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
    end
    chk("t3_ready_low", 64'(in_ready), 64'd0);
    chk("t3_stall", 64'(stall_cnt), 64'd2);
    out_ready = 1'b1;
    tick();
    chk("t3_ready_back", 64'(in_ready), 64'd1);
    chk("t3_head2", 64'(out_result), 64'd2);
    tick();
    chk("t3_head3", 64'(out_result), 64'd3);
    in_valid = 1'b0;
    tick();
    chk("t3_drained", 64'(out_valid), 64'd0);
    chk("t3_sb_empty", 64'(sb.size()), 64'd0);
    chk("t3_stall_hold", 64'(stall_cnt), 64'd2);
    out_ready = 1'b0;
    drive(32'hA1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(32'hA2, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("t4_full", 64'(in_ready), 64'd0);
    flush = 1'b1;
    drive(32'hBAD, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("t4_flush_valid", 64'(out_valid), 64'd0);
    chk("t4_flush_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (2) tick();
    chk("t4_no_ghost", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
    drive(32'hC1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    flush = 1'b1;
    drive(32'hC2, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("t4b_flush_valid", 64'(out_valid), 64'd0);
    chk("t4b_flush_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (2) tick();
    chk("t4b_no_ghost", 64'(out_valid), 64'd0);
    drive(32'h80000000, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("t5_ovf", 64'(out_ovf), 64'd1);
    chk("t5_wren", 64'(out_wren), 64'd0);
    chk("t5_rd", 64'(out_rd), 64'd0);
    chk("t5_result", 64'(out_result), 64'h80000000);
    tick();
    out_ready = 1'b0;
    drive(32'hD1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    repeat (20) tick();
    chk("t6_saturated", 64'(stall_cnt), 64'd15);
    chk("t6_stalled", 64'(out_valid), 64'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("t6_async_valid", 64'(out_valid), 64'd0);
    chk("t6_async_stall", 64'(stall_cnt), 64'd0);
    chk("t6_async_result", 64'(out_result), 64'd0);
    chk("t6_async_ready", 64'(in_ready), 64'd1);
    tick();
    #2;
    resetn = 1'b1;
    tick();
    chk("t6_post_ready", 64'(in_ready), 64'd1);
    chk("t6_post_valid", 64'(out_valid), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
